// File: rtl/vga_pkg.sv
// vga_pkg: shared geometry, slot/op types and the (x,y) to linear-address mapping for the VRAM arbiter.
package vga_pkg;
  localparam int H_ACTIVE = 320;
  localparam int V_ACTIVE = 240;
  localparam int ADDR_WIDTH = 17;
  localparam logic [7:0] READ_FILL = 8'h00;
  typedef logic [1:0] slot_t;
  typedef enum logic [1:0] {OP_NONE, OP_VIDEO, OP_READ, OP_WRITE} op_t;
  function automatic logic [ADDR_WIDTH-1:0] xy_to_addr(input logic [8:0] x, input logic [7:0] y);
    logic [ADDR_WIDTH-1:0] yy;
    yy = ADDR_WIDTH'(y);
    // 320 = 256 + 64, so the default geometry needs only shifts and adds
    return (H_ACTIVE == 320) ? (yy << 8) + (yy << 6) + ADDR_WIDTH'(x)
                             : yy * ADDR_WIDTH'(H_ACTIVE) + ADDR_WIDTH'(x);
  endfunction
endpackage

// File: rtl/vram_addr_gen.sv
// vram_addr_gen: maps a pixel coordinate to its SRAM address and flags whether it lies on screen.
module vram_addr_gen
  import vga_pkg::*;
(
  input  logic [8:0]            x_i,
  input  logic [7:0]            y_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  valid_o
);
  always_comb begin
    addr_o = xy_to_addr(x_i, y_i);
    valid_o = x_i < 9'(H_ACTIVE) && y_i < 8'(V_ACTIVE);
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: 4-slot time-sliced SRAM arbiter, slots 0-1 video fetch and slots 2-3 MPU access.
// Define VRAM_ARBITER_BLANK_BOOST_EN to turn slots 0-1 into a second MPU window while video is blanked.
module vram_arbiter
  import vga_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  output logic [1:0]            slot,
  input  logic                  videoActive,
  input  logic [8:0]            videoXCoord,
  input  logic [7:0]            videoYCoord,
  output logic [7:0]            videoData,
  output logic                  videoDataReady,
  input  logic [8:0]            memoryXCoord,
  input  logic [7:0]            memoryYCoord,
  input  logic                  memoryReadRequest,
  input  logic                  memoryWriteRequest,
  input  logic [7:0]            memoryWriteData,
  output logic [7:0]            memoryReadData,
  output logic                  memoryReadComplete,
  output logic                  memoryWriteComplete,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  input  logic [7:0]            ramDataIn,
  output logic [7:0]            ramDataOut,
  output logic                  ramDataOutEnable,
  output logic                  ramWriteEnable,
  output logic                  ramOutputEnable
);
  slot_t slot_q, slot_d;
  op_t op_q, op_d, next_op;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, v_addr, m_addr;
  logic [7:0] dout_q, dout_d, vdata_q, vdata_d, rdata_q, rdata_d;
  logic oe_n_q, oe_n_d, we_n_q, we_n_d, doe_q, doe_d, vrdy_q, vrdy_d;
  logic rcmp_q, rcmp_d, wcmp_q, wcmp_d, valid_q, valid_d;
  logic m_valid, v_valid_unused, boost, win_edge;
  vram_addr_gen u_vid (.x_i(videoXCoord), .y_i(videoYCoord), .addr_o(v_addr), .valid_o(v_valid_unused));
  vram_addr_gen u_mpu (.x_i(memoryXCoord), .y_i(memoryYCoord), .addr_o(m_addr), .valid_o(m_valid));
`ifdef VRAM_ARBITER_BLANK_BOOST_EN
  assign boost = !videoActive;
`else
  logic active_unused;
  assign active_unused = videoActive;
  assign boost = 1'b0;
`endif
  assign win_edge = slot_q[0];
  // The type completing at a window edge is not re-granted there: its requester has not yet seen the strobe
  assign next_op = (slot_q == 2'd3 && !boost) ? OP_VIDEO
                 : (memoryWriteRequest && op_q != OP_WRITE) ? OP_WRITE
                 : (memoryReadRequest && op_q != OP_READ) ? OP_READ : OP_NONE;
  always_comb begin
    slot_d = slot_q + 2'd1;
    vrdy_d = win_edge && op_q == OP_VIDEO;
    rcmp_d = win_edge && op_q == OP_READ;
    wcmp_d = win_edge && op_q == OP_WRITE;
    vdata_d = vrdy_d ? ramDataIn : vdata_q;
    rdata_d = rcmp_d ? (valid_q ? ramDataIn : READ_FILL) : rdata_q;
    op_d = win_edge ? next_op : op_q;
    valid_d = win_edge ? m_valid : valid_q;
    addr_d = (!win_edge || next_op == OP_NONE) ? addr_q : next_op == OP_VIDEO ? v_addr : m_addr;
    oe_n_d = win_edge ? !(next_op == OP_VIDEO || next_op == OP_READ) : oe_n_q;
    we_n_d = !(win_edge && next_op == OP_WRITE && m_valid);
    doe_d = win_edge ? next_op == OP_WRITE : doe_q;
    dout_d = (win_edge && next_op == OP_WRITE) ? memoryWriteData : dout_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      slot_q <= '0; op_q <= OP_NONE; addr_q <= '0; dout_q <= '0; vdata_q <= '0; rdata_q <= '0;
      oe_n_q <= 1'b1; we_n_q <= 1'b1; doe_q <= 1'b0; vrdy_q <= 1'b0;
      rcmp_q <= 1'b0; wcmp_q <= 1'b0; valid_q <= 1'b0;
    end else begin
      slot_q <= slot_d; op_q <= op_d; addr_q <= addr_d; dout_q <= dout_d; vdata_q <= vdata_d; rdata_q <= rdata_d;
      oe_n_q <= oe_n_d; we_n_q <= we_n_d; doe_q <= doe_d; vrdy_q <= vrdy_d;
      rcmp_q <= rcmp_d; wcmp_q <= wcmp_d; valid_q <= valid_d;
    end
  assign slot = slot_q;
  assign videoData = vdata_q;
  assign videoDataReady = vrdy_q;
  assign memoryReadData = rdata_q;
  assign memoryReadComplete = rcmp_q;
  assign memoryWriteComplete = wcmp_q;
  assign ramAddress = addr_q;
  assign ramDataOut = dout_q;
  assign ramDataOutEnable = doe_q;
  assign ramWriteEnable = we_n_q;
  assign ramOutputEnable = oe_n_q;
endmodule
